// File: rtl/ste_match_pkg.sv
// Shared defaults and helpers for the programmable STE literal matcher.
// Holds width helpers and the saturating increment used by the counters.
package ste_match_pkg;

  localparam int CHAR_W_DEFAULT = 8;

  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  function automatic int len_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] top;
    if (w >= 64) begin
      top = {64{1'b1}};
    end else begin
      top = (64'd1 << w) - 64'd1;
    end
    if (v >= top) begin
      return v;
    end else begin
      return v + 64'd1;
    end
  endfunction

endpackage

// File: rtl/ste_cell.sv
// One STE position: programmable literal/wildcard, compare, and the
// active-state flip-flop fed by its predecessor.
module ste_cell
  import ste_match_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [CHAR_W-1:0] cfg_char,
  input  logic              cfg_wild,
  input  logic              clr,
  input  logic              acc,
  input  logic              last,
  input  logic [CHAR_W-1:0] character,
  input  logic              pred,
  output logic              s,
  output logic              n
);

  logic [CHAR_W-1:0] pat_r;
  logic              wild_r;
  logic              s_r;
  logic              eq_s;

  // Position compare and next-state term.
  always_comb begin
    eq_s = wild_r || (character == pat_r);
    n    = pred && eq_s;
  end

  // Pattern registers, written only through the config port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pat_r  <= {CHAR_W{1'b0}};
      wild_r <= 1'b0;
    end else if (wr) begin
      pat_r  <= cfg_char;
      wild_r <= cfg_wild;
    end
  end

  // Active-state flop; a record end never carries partial matches forward.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_r <= 1'b0;
    end else if (clr) begin
      s_r <= 1'b0;
    end else if (acc) begin
      s_r <= last ? 1'b0 : n;
    end
  end

  assign s = s_r;

endmodule

// File: rtl/ste_chain_matcher.sv
// Programmable homogeneous-NFA literal matcher with record boundaries,
// anchored mode, and match position / count reporting.
module ste_chain_matcher
  import ste_match_pkg::*;
#(
  parameter int CHAR_W  = CHAR_W_DEFAULT,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 32,
  localparam int IDX_W  = idx_width(MAX_LEN),
  localparam int LEN_W  = len_width(MAX_LEN)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [CHAR_W-1:0] cfg_char,
  input  logic              cfg_wild,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_anchored,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] character,
  input  logic              in_last,
  output logic              result,
  output logic [CNT_W-1:0]  match_pos,
  output logic [CNT_W-1:0]  match_count,
  output logic              HBM_CATTRIP
);

  logic [MAX_LEN-1:0] s_s, n_s, pred_s;
  logic               acc_s, clr_s, start_ok_s, hit_s;
  logic [LEN_W-1:0]   len_r, len_clamp_s;
  logic               anchored_r, at_start_r, result_r;
  logic [CNT_W-1:0]   offset_r, match_pos_r, match_count_r;
  logic [63:0]        off_inc_s, cnt_inc_s;

  assign acc_s = enable && in_valid;
  // Config is only honoured while matching is disabled; any write restarts the chain.
  assign clr_s = !enable && (cfg_we || cfg_len_we);

  // Anchored patterns may only start on the first character of a record.
  always_comb begin
    if (anchored_r) begin
      start_ok_s = at_start_r;
    end else begin
      start_ok_s = 1'b1;
    end
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cell
    if (i == 0) begin : g_head
      assign pred_s[i] = start_ok_s;
    end else begin : g_link
      assign pred_s[i] = s_s[i-1];
    end

    ste_cell #(.CHAR_W(CHAR_W)) u_cell (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr        (!enable && cfg_we && (cfg_idx == IDX_W'(i))),
      .cfg_char  (cfg_char),
      .cfg_wild  (cfg_wild),
      .clr       (clr_s),
      .acc       (acc_s),
      .last      (in_last),
      .character (character),
      .pred      (pred_s[i]),
      .s         (s_s[i]),
      .n         (n_s[i])
    );
  end

  // Select the final position's term; len of zero selects nothing.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (len_r == LEN_W'(i + 1)) begin
        hit_s = n_s[i];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Length clamp to the number of physical positions.
  always_comb begin
    if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_clamp_s = LEN_W'(MAX_LEN);
    end else begin
      len_clamp_s = cfg_len;
    end
  end

  assign off_inc_s = sat_inc(64'(offset_r), CNT_W);
  assign cnt_inc_s = sat_inc(64'(match_count_r), CNT_W);

  // Length/mode, record offset, match reporting and result pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      len_r         <= {LEN_W{1'b0}};
      anchored_r    <= 1'b0;
      at_start_r    <= 1'b1;
      offset_r      <= {CNT_W{1'b0}};
      match_pos_r   <= {CNT_W{1'b0}};
      match_count_r <= {CNT_W{1'b0}};
      result_r      <= 1'b0;
    end else begin
      if (!enable && cfg_len_we) begin
        len_r      <= len_clamp_s;
        anchored_r <= cfg_anchored;
      end
      if (clr_s) begin
        at_start_r <= 1'b1;
      end else if (acc_s) begin
        at_start_r <= in_last;
        offset_r   <= in_last ? {CNT_W{1'b0}} : off_inc_s[CNT_W-1:0];
        if (hit_s) begin
          match_pos_r   <= offset_r;
          match_count_r <= cnt_inc_s[CNT_W-1:0];
        end
      end
      result_r <= acc_s && hit_s;
    end
  end

  assign result      = result_r;
  assign match_pos   = match_pos_r;
  assign match_count = match_count_r;
  assign HBM_CATTRIP = 1'b0;

endmodule

// File: tb/tb_ste_chain_matcher.sv
// Scoreboard bench for ste_chain_matcher: a record-buffer reference model
// predicts result/match_pos/match_count for every cycle.
module tb_ste_chain_matcher;

  localparam int CHAR_W  = 8;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_idx = 4'd0;
  logic [CHAR_W-1:0] cfg_char = 8'd0;
  logic              cfg_wild = 1'b0;
  logic              cfg_len_we = 1'b0;
  logic [4:0]        cfg_len = 5'd0;
  logic              cfg_anchored = 1'b0;
  logic              in_valid = 1'b0;
  logic [CHAR_W-1:0] character = 8'd0;
  logic              in_last = 1'b0;
  logic              result;
  logic [CNT_W-1:0]  match_pos;
  logic [CNT_W-1:0]  match_count;
  logic              hbm_cattrip;

  ste_chain_matcher #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_char     (cfg_char),
    .cfg_wild     (cfg_wild),
    .cfg_len_we   (cfg_len_we),
    .cfg_len      (cfg_len),
    .cfg_anchored (cfg_anchored),
    .in_valid     (in_valid),
    .character    (character),
    .in_last      (in_last),
    .result       (result),
    .match_pos    (match_pos),
    .match_count  (match_count),
    .HBM_CATTRIP  (hbm_cattrip)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          res;
    logic [31:0] pos;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  logic [7:0]  m_pat[MAX_LEN];
  bit          m_wild[MAX_LEN];
  int          m_len;
  bit          m_anch;
  logic [7:0]  m_buf[$];
  logic [31:0] m_off, m_pos, m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAX_LEN; i++) begin
      m_pat[i]  = 8'd0;
      m_wild[i] = 1'b0;
    end
    m_len = 0; m_anch = 1'b0;
    m_buf.delete();
    m_off = 32'd0; m_pos = 32'd0; m_cnt = 32'd0;
  endtask

  // Predict this cycle from the driven inputs, clock once, then compare.
  task automatic step(input string tag);
    exp_t e, o;
    bit   hit;
    int   b;
    hit = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else if (enable && in_valid) begin
      m_buf.push_back(character);
      b = m_buf.size();
      if (m_len != 0 && b >= m_len && (!m_anch || b == m_len)) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (!m_wild[k] && m_buf[b - m_len + k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) begin
        m_pos = m_off;
        m_cnt = m_cnt + 32'd1;
      end
      m_off = in_last ? 32'd0 : m_off + 32'd1;
      if (in_last) m_buf.delete();
    end else if (!enable) begin
      if (cfg_we) begin
        m_pat[cfg_idx]  = cfg_char;
        m_wild[cfg_idx] = cfg_wild;
      end
      if (cfg_len_we) begin
        m_len  = (cfg_len > 5'd16) ? 16 : int'(cfg_len);
        m_anch = cfg_anchored;
      end
      if (cfg_we || cfg_len_we) m_buf.delete();
    end
    e.res = hit; e.pos = m_pos; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      o = sb.pop_front();
      check_eq({tag, "_result"}, 64'(result), 64'(o.res));
      check_eq({tag, "_pos"}, 64'(match_pos), 64'(o.pos));
      check_eq({tag, "_count"}, 64'(match_count), 64'(o.cnt));
    end
  endtask

  task automatic set_pos(input int idx, input logic [7:0] c, input bit w);
    enable = 1'b0; cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_char = c; cfg_wild = w;
    step("cfg_pos");
    cfg_we = 1'b0;
  endtask

  task automatic set_len(input int l, input bit a);
    enable = 1'b0; cfg_len_we = 1'b1; cfg_len = 5'(l); cfg_anchored = a;
    step("cfg_len");
    cfg_len_we = 1'b0;
  endtask

  // '?' in the pattern string loads a wildcard position.
  task automatic load(input string p, input bit a);
    for (int i = 0; i < p.len(); i++)
      set_pos(i, (p[i] == "?") ? 8'd0 : p[i], p[i] == "?");
    set_len(p.len(), a);
  endtask

  task automatic send(input logic [7:0] c, input bit last, input string tag);
    enable = 1'b1; in_valid = 1'b1; character = c; in_last = last;
    step(tag);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_at_end, input string tag);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_at_end && (i == s.len() - 1), tag);
  endtask

  task automatic idle(input int n, input string tag);
    in_valid = 1'b0;
    repeat (n) step(tag);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    step("reset");
    step("reset");
    reset_n = 1'b1;
    check_eq("cattrip", 64'(hbm_cattrip), 64'd0);

    // 1: unanchored ROMEO inside xROMEOy
    load("ROMEO", 1'b0);
    send_str("xROMEOy", 1'b1, "t1");
    idle(1, "t1_idle");

    // 2: overlapping AA in AAAA
    load("AA", 1'b0);
    send_str("AAAA", 1'b1, "t2");

    // 3: anchored RO across two records
    load("RO", 1'b1);
    send_str("RORO", 1'b1, "t3a");
    send_str("RO", 1'b1, "t3b");

    // 4: idle gaps keep state; record end breaks a match
    load("RO", 1'b0);
    send("R", 1'b0, "t4a");
    idle(3, "t4_gap");
    send("O", 1'b0, "t4b");
    send("R", 1'b1, "t4c");
    send("O", 1'b0, "t4d");

    // 5: wildcard middle position; config write ignored while enabled
    load("R?M", 1'b0);
    send_str("RXM", 1'b0, "t5a");
    send_str("RMM", 1'b1, "t5b");
    enable = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd1; cfg_char = "Z"; cfg_wild = 1'b0;
    step("t5_cfg_locked");
    cfg_we = 1'b0;
    send_str("RQM", 1'b1, "t5c");

    // len 0 never matches; oversize length clamps to all positions
    set_len(0, 1'b0);
    send_str("RXMRXM", 1'b1, "len0");
    for (int i = 0; i < MAX_LEN; i++) set_pos(i, 8'd0, 1'b1);
    set_len(31, 1'b0);
    for (int i = 0; i < 18; i++) send(8'(65 + i), i == 17, "clamp");

    // 6: reset mid-match discards partial state and pattern
    load("ROMEO", 1'b0);
    send_str("ROM", 1'b0, "t6a");
    reset_n = 1'b0;
    step("t6_reset");
    reset_n = 1'b1;
    send_str("EO", 1'b1, "t6b");
    send_str("ROMEO", 1'b1, "t6c");
    idle(1, "t6_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ste_chain_matcher.md
Name: ste_chain_matcher

Overview:
Parametrised successor to the fixed-literal STE chain. It is a programmable homogeneous-NFA literal matcher for one character stream. The pattern (up to MAX_LEN positions, each with a per-position wildcard) is loaded through a config port. Beyond a bare match pulse it adds:
- valid-gated streaming,
- record boundaries,
- an anchored mode,
- match position and match count reporting.
It sits between the character stream source and the report collector in the automata top level, replacing hand-written STEn/FF chains.

Parameters:
CHAR_W, 8, character width in bits
MAX_LEN, 16, maximum pattern length (number of STE positions)
CNT_W, 32, width of position and match counters

Ports:
clock  in  1  sole clock, all logic on posedge
reset_n  in  1  synchronous active-low reset
enable  in  1  1 = matching active; config writes accepted only while 0
cfg_we  in  1  write one pattern position
cfg_idx  in  $clog2(MAX_LEN)  position written
cfg_char  in  CHAR_W  literal for that position
cfg_wild  in  1  1 = position matches any character
cfg_len_we  in  1  write pattern length and mode
cfg_len  in  $clog2(MAX_LEN+1)  pattern length
cfg_anchored  in  1  1 = match only from record start
in_valid  in  1  character present this cycle
character  in  CHAR_W  stream character
in_last  in  1  character is last of current record
result  out  1  registered one-cycle match pulse
match_pos  out  CNT_W  record offset of last character of most recent match
match_count  out  CNT_W  total matches since reset, saturating
HBM_CATTRIP  out  1  tied 1'b0

Behaviour:
Reset (reset_n=0 at posedge):
- s[MAX_LEN-1:0]=0.
- result=0, match_pos=0, match_count=0.
- offset=0, at_start=1.
- Pattern registers cleared: char=0, wild=0, len=0, anchored=0.
- Reset mid-match discards all partial state.

Accept condition: acc = enable && in_valid. When acc=0, all state holds and result=0 next cycle.

Per accepted character:
- eq[i] = wild[i] || (character == pat[i]).
- start_ok = anchored ? at_start : 1.
- n[0] = start_ok && eq[0]; n[i] = s[i-1] && eq[i] for i≥1.
- hit = (len != 0) && n[len-1].

Registered update on acc:
- s <= in_last ? 0 : n. A match on the last character still reports; no match spans records.
- at_start <= in_last.
- offset <= in_last ? 0 : offset+1, saturating at all-ones.
- result <= hit.
- On hit: match_pos <= offset (current character's offset), and match_count <= match_count+1, saturating.

Timing and edge cases:
- Latency: result is asserted in the cycle after the accepting character is presented.
- Overlapping matches are all reported, one per accepting character.
- len=0: never matches.
- cfg_len > MAX_LEN is clamped to MAX_LEN.
- Positions ≥ len are ignored.

Config rules:
- Config writes (cfg_we, cfg_len_we) are honoured only when enable=0 and are ignored otherwise.
- Any honoured config write clears s and sets at_start=1. It does not touch offset or the counters.
- Simultaneous cfg_we and cfg_len_we are both applied.

Decomposition:
- Package ste_match_pkg holds the default CHAR_W, the index/length width helpers, and the saturating-increment function.
- Natural sub-module ste_cell: one position holding the pat/wild registers, the compare, and the s flip-flop with predecessor input.
- Top instantiates MAX_LEN ste_cells via generate, plus the length mux, offset/count logic and result register.

Test Plan:
1. Pattern "ROMEO", len 5, unanchored; stream "xROMEOy", in_valid=1 every cycle → result high for exactly the one cycle after the final 'O'; match_pos=5, match_count=1.
2. Pattern "AA"; stream "AAAA" → three result pulses on consecutive cycles; match_pos 1, 2, 3; match_count=3.
3. Anchored "RO"; record "RORO" (in_last on 4th char), then record "RO" → match at offset 1 of record 1 only, then match at offset 1 of record 2; match_count=2.
4. Pattern "RO"; "R", 3 idle cycles, "O" → match. Then "R" with in_last followed by "O" → no match.
5. Pattern R,wild,M; stream "RXM", "RMM" → two matches. Attempt cfg_we with enable=1 → pattern unchanged.
6. Pattern "ROMEO"; stream "ROM", reset_n low one cycle, then "EO" → no result pulse; match_count=0, match_pos=0, pattern len=0.
